mmio_bridge: RTL and testbench
==============================

# mmio_bridge

Memory-mapped I/O bridge between the processor's M stage and the data memory. It decodes the 12-bit M-stage address and routes each access to one of three places: dmem, a PS/2 key receive FIFO, or an LCD transmit FIFO. The LCD FIFO is drained to the LCD port by a paced state machine. Programs reach the keyboard and display with ordinary lw/sw.

## Interface
Parameters:
- KEY_DEPTH, 8: key FIFO entries (power of 2).
- LCD_DEPTH, 4: LCD FIFO entries (power of 2).
- LCD_GAP, 2: idle cycles after each lcd_write pulse (≥0).

Ports:
- clock, in, 1: single clock; all state updates on posedge.
- reset, in, 1: synchronous, active-low.
- cpu_address, in, 12: M-stage address.
- cpu_wdata, in, 32: M-stage store data.
- cpu_wren, in, 1: M-stage sw.
- cpu_ren, in, 1: M-stage lw.
- cpu_rdata, out, 32: load data to M/W register; combinational.
- dmem_wren, out, 1: write enable to dmem.
- dmem_q, in, 32: dmem read data.
- ps2_key_pressed, in, 1: key strobe (level; rising edge = new key).
- ps2_out, in, 8: scancode, valid when ps2_key_pressed is high.
- lcd_write, out, 1: one-cycle write pulse.
- lcd_data, out, 32: LCD word; valid while lcd_write=1.

## Operation
- Address map (constants):
  - KEY_DATA = 0xFF0
  - KEY_STAT = 0xFF1
  - LCD_DATA = 0xFF2
  - LCD_STAT = 0xFF3
  - All other addresses go to dmem.
- dmem_wren = cpu_wren && address not in 0xFF0–0xFF3. Stores to MMIO never reach dmem.
- Load data:
  - dmem addresses: cpu_rdata = dmem_q.
  - KEY_DATA: {24'b0, head scancode}, or 0 if empty.
  - KEY_STAT: {23'b0, key_ovf, 8'(key_count)}.
  - LCD_STAT: {23'b0, lcd_ovf, 8'(lcd_count)}.
  - LCD_DATA load returns 0.
- Key FIFO:
  - Push: on rising edge of ps2_key_pressed (registered previous level), push ps2_out.
  - Overflow: if full, drop the byte and set sticky key_ovf.
  - Pop: on a cpu_ren cycle at KEY_DATA when non-empty. A read while empty has no side effect.
  - Simultaneous push and pop: both occur; count unchanged. This holds when full: pop frees the slot, push succeeds, no overflow.
  - key_ovf clears on a cpu_ren at KEY_STAT (the read returns 1, then clears). If a new overflow occurs in the same cycle, set wins.
- LCD FIFO:
  - Push: cpu_wren at LCD_DATA pushes cpu_wdata.
  - Overflow: if full, drop the word and set sticky lcd_ovf. Cleared by a read at LCD_STAT, same rule as key_ovf.
  - Simultaneous push and drain pop: both occur.
- Drain FSM (per-edge transitions):
  - IDLE: if non-empty → SEND.
  - SEND: lcd_write=1, lcd_data=head; pop. Next state is GAP if LCD_GAP>0, else SEND if still non-empty, else IDLE.
  - GAP: count LCD_GAP cycles, then go to SEND if non-empty, else IDLE.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Counts are log2(DEPTH)+1 bits, range 0..DEPTH.

## Timing
- Reset (reset=0 at a posedge) clears:
  - both FIFOs (count and pointers 0), both overflow flags, the edge register, FSM → IDLE.
  - Outputs: lcd_write=0, lcd_data=0 (whenever not SEND), cpu_rdata follows its mux (0 for MMIO reads), dmem_wren combinational.
- Reset takes priority over all same-cycle events. A reset asserted mid-drain discards queued words and the in-progress gap.
- Key latency: a rising edge sampled at posedge N makes the key visible to reads from cycle N+1 onward.
- LCD latency: an sw to LCD_DATA at edge N with the FSM in IDLE and the FIFO empty gives lcd_write=1 during cycle N+1 (IDLE→SEND at edge N+1; Moore output in SEND, so it appears from edge N+1).
- Throughput: one word per LCD_GAP+1 cycles.
- ps2_key_pressed held high for many cycles pushes once.

## Structure
- Package mmio_pkg holds the four address constants, the FSM state enum {IDLE, SEND, GAP}, and the status-word field positions.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH), instantiated twice (8-bit key FIFO, 32-bit LCD FIFO). It exposes push, pop, head, count, full, empty and has no overflow logic.
- Address decode, overflow flags, edge detect and the drain FSM live in mmio_bridge.

## Test plan
- Reset then dmem passthrough: sw 0x1234 @0x010 → dmem_wren=1; lw @0x010 with dmem_q=0x1234 → cpu_rdata=0x1234; sw @0xFF2 → dmem_wren=0.
- Key FIFO:
  - Three rising edges with scancodes 0x1C, 0x32, 0x21 → KEY_STAT=3.
  - Three KEY_DATA reads return 0x1C, 0x32, 0x21.
  - A fourth read returns 0 and KEY_STAT=0.
- Key overflow: 9 key edges with KEY_DEPTH=8 → KEY_STAT=0x108; a second KEY_STAT read returns 0x008; drained data is the first 8 codes.
- LCD pacing, LCD_GAP=2: back-to-back sw of 0xA, 0xB → lcd_write pulses exactly 3 cycles apart carrying 0xA then 0xB; lcd_write=0 otherwise.
- LCD overflow plus simultaneity: 6 consecutive sw with the drain active → first pulse carries word 1; LCD_STAT reports lcd_ovf=1; exactly one word is dropped (word 6).
- Mid-operation reset: reset=0 for one cycle while lcd_count=3 and in GAP → next cycle lcd_write=0, LCD_STAT=0, KEY_STAT=0, and no further pulses.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bridge: address map, drain FSM states and
// the layout of the two status words.
package mmio_pkg;

    // Memory-mapped register addresses; everything else belongs to dmem.
    localparam logic [11:0] KEY_DATA = 12'hFF0;
    localparam logic [11:0] KEY_STAT = 12'hFF1;
    localparam logic [11:0] LCD_DATA = 12'hFF2;
    localparam logic [11:0] LCD_STAT = 12'hFF3;

    // Status word layout: {23'b0, ovf, count[7:0]}.
    localparam int STAT_CNT_LSB = 0;
    localparam int STAT_CNT_W   = 8;
    localparam int STAT_OVF_BIT = 8;

    // LCD drain state machine.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } drain_state_t;

    // True for the four MMIO registers (0xFF0..0xFF3 share the upper 10 bits).
    function automatic logic is_mmio(input logic [11:0] addr);
        return addr[11:2] == KEY_DATA[11:2];
    endfunction

    // Pack an overflow flag and a FIFO occupancy into a status word.
    function automatic logic [31:0] stat_word(input logic ovf, input logic [7:0] cnt);
        logic [31:0] w;
        w = '0;
        w[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
        w[STAT_OVF_BIT] = ovf;
        return w;
    endfunction

endpackage

// File: rtl/mmio_bridge_fifo.sv
// Synchronous FIFO with first-word-fall-through head, used for both the key
// receive queue and the LCD transmit queue. Overflow policy belongs to the
// caller; this block only refuses pushes it has no room for.
//
// Handshake: push is a request qualified by (!full || pop) -- a push on a
// full FIFO is accepted only when a pop frees the slot in the same cycle.
// pop is honoured only when !empty; head is valid whenever !empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (reset && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_bridge.sv
// M-stage MMIO bridge: decodes the 12-bit address, steers stores to dmem or
// the LCD queue, serves loads from dmem or the MMIO registers, captures PS/2
// scancodes into a key queue and paces LCD words out through a drain FSM.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int KEY_DEPTH = 8,
    parameter int LCD_DEPTH = 4,
    parameter int LCD_GAP   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] cpu_address,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_wren,
    input  logic        cpu_ren,
    output logic [31:0] cpu_rdata,
    output logic        dmem_wren,
    input  logic [31:0] dmem_q,
    input  logic        ps2_key_pressed,
    input  logic [7:0]  ps2_out,
    output logic        lcd_write,
    output logic [31:0] lcd_data
);

    localparam int KAW   = $clog2(KEY_DEPTH);
    localparam int LAW   = $clog2(LCD_DEPTH);
    localparam int GAP_W = (LCD_GAP > 1) ? $clog2(LCD_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (LCD_GAP > 0) ? GAP_W'(LCD_GAP - 1) : '0;

    // Address decode strobes.
    logic key_data_rd;
    logic key_stat_rd;
    logic lcd_stat_rd;
    logic lcd_data_wr;

    assign key_data_rd = cpu_ren  && (cpu_address == KEY_DATA);
    assign key_stat_rd = cpu_ren  && (cpu_address == KEY_STAT);
    assign lcd_stat_rd = cpu_ren  && (cpu_address == LCD_STAT);
    assign lcd_data_wr = cpu_wren && (cpu_address == LCD_DATA);
    assign dmem_wren   = cpu_wren && !is_mmio(cpu_address);

    // ---------------- key receive path ----------------
    logic           key_prev;
    logic           key_rise;
    logic           key_push;
    logic           key_pop;
    logic           key_ovf;
    logic           key_ovf_set;
    logic [7:0]     key_head;
    logic [KAW:0]   key_count;
    logic           key_full;
    logic           key_empty;

    assign key_rise    = ps2_key_pressed && !key_prev;
    assign key_pop     = key_data_rd && !key_empty;
    // A pop in the same cycle makes room, so a full queue still accepts.
    assign key_push    = key_rise && (!key_full || key_pop);
    assign key_ovf_set = key_rise && key_full && !key_pop;

    // Previous strobe level so a held key produces one push.
    always_ff @(posedge clock) begin
        if (!reset) key_prev <= 1'b0;
        else        key_prev <= ps2_key_pressed;
    end

    // Sticky key overflow; a new overflow beats a clearing status read.
    always_ff @(posedge clock) begin
        if (!reset)           key_ovf <= 1'b0;
        else if (key_ovf_set) key_ovf <= 1'b1;
        else if (key_stat_rd) key_ovf <= 1'b0;
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (KEY_DEPTH)
    ) u_key_fifo (
        .clock (clock),
        .reset (reset),
        .push  (key_push),
        .pop   (key_pop),
        .din   (ps2_out),
        .head  (key_head),
        .count (key_count),
        .full  (key_full),
        .empty (key_empty)
    );

    // ---------------- LCD transmit path ----------------
    drain_state_t   drain_state;
    drain_state_t   drain_next;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_next;
    logic           lcd_push;
    logic           lcd_pop;
    logic           lcd_ovf;
    logic           lcd_ovf_set;
    logic [31:0]    lcd_head;
    logic [LAW:0]   lcd_count;
    logic           lcd_full;
    logic           lcd_empty;

    assign lcd_pop     = (drain_state == SEND);
    assign lcd_push    = lcd_data_wr && (!lcd_full || lcd_pop);
    assign lcd_ovf_set = lcd_data_wr && lcd_full && !lcd_pop;

    // Sticky LCD overflow; a new overflow beats a clearing status read.
    always_ff @(posedge clock) begin
        if (!reset)           lcd_ovf <= 1'b0;
        else if (lcd_ovf_set) lcd_ovf <= 1'b1;
        else if (lcd_stat_rd) lcd_ovf <= 1'b0;
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (LCD_DEPTH)
    ) u_lcd_fifo (
        .clock (clock),
        .reset (reset),
        .push  (lcd_push),
        .pop   (lcd_pop),
        .din   (cpu_wdata),
        .head  (lcd_head),
        .count (lcd_count),
        .full  (lcd_full),
        .empty (lcd_empty)
    );

    // Drain FSM state and gap counter registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            drain_state <= IDLE;
            gap_cnt     <= '0;
        end else begin
            drain_state <= drain_next;
            gap_cnt     <= gap_next;
        end
    end

    // Drain FSM next state: one SEND cycle per word, then LCD_GAP idle cycles.
    // With no gap, SEND repeats while words remain after this cycle's pop
    // (a concurrent store counts as a remaining word).
    always_comb begin
        drain_next = drain_state;
        gap_next   = gap_cnt;
        case (drain_state)
            IDLE: begin
                if (!lcd_empty) drain_next = SEND;
            end
            SEND: begin
                gap_next = '0;
                if (LCD_GAP > 0)
                    drain_next = GAP;
                else if ((lcd_count > (LAW + 1)'(1)) || lcd_data_wr)
                    drain_next = SEND;
                else
                    drain_next = IDLE;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST)
                    drain_next = lcd_empty ? IDLE : SEND;
                else
                    gap_next = gap_cnt + 1'b1;
            end
            default: drain_next = IDLE;
        endcase
    end

    // Moore outputs of the drain FSM.
    assign lcd_write = (drain_state == SEND);
    assign lcd_data  = lcd_write ? lcd_head : '0;

    // Load data mux; MMIO registers override dmem.
    always_comb begin
        cpu_rdata = dmem_q;
        case (cpu_address)
            KEY_DATA: cpu_rdata = key_empty ? 32'd0 : {24'd0, key_head};
            KEY_STAT: cpu_rdata = stat_word(key_ovf, 8'(key_count));
            LCD_DATA: cpu_rdata = 32'd0;
            LCD_STAT: cpu_rdata = stat_word(lcd_ovf, 8'(lcd_count));
            default:  cpu_rdata = dmem_q;
        endcase
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: table-driven register accesses plus
// hand-written sequences for key/LCD queueing, pacing, overflow and reset.
module tb_mmio_bridge;

  localparam int KEY_DEPTH = 8;
  localparam int LCD_DEPTH = 4;
  localparam int LCD_GAP   = 2;

  localparam logic [11:0] A_KEY_DATA = 12'hFF0;
  localparam logic [11:0] A_KEY_STAT = 12'hFF1;
  localparam logic [11:0] A_LCD_DATA = 12'hFF2;
  localparam logic [11:0] A_LCD_STAT = 12'hFF3;

  logic        clock;
  logic        reset;
  logic [11:0] cpu_address;
  logic [31:0] cpu_wdata;
  logic        cpu_wren;
  logic        cpu_ren;
  logic [31:0] cpu_rdata;
  logic        dmem_wren;
  logic [31:0] dmem_q;
  logic        ps2_key_pressed;
  logic [7:0]  ps2_out;
  logic        lcd_write;
  logic [31:0] lcd_data;

  int checks;
  int errors;
  int cyc;
  int last_pulse;
  int burst_n;
  logic mon_en;

  logic [31:0] exp_q[$];
  logic [7:0]  key_q[$];

  typedef struct {
    string       nm;
    logic        ren;
    logic        wren;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] dq;
    logic [31:0] exp_rdata;
    logic        exp_dwren;
  } vec_t;

  vec_t tbl_a[10];
  vec_t tbl_b[6];

  mmio_bridge #(
    .KEY_DEPTH (KEY_DEPTH),
    .LCD_DEPTH (LCD_DEPTH),
    .LCD_GAP   (LCD_GAP)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .cpu_address     (cpu_address),
    .cpu_wdata       (cpu_wdata),
    .cpu_wren        (cpu_wren),
    .cpu_ren         (cpu_ren),
    .cpu_rdata       (cpu_rdata),
    .dmem_wren       (dmem_wren),
    .dmem_q          (dmem_q),
    .ps2_key_pressed (ps2_key_pressed),
    .ps2_out         (ps2_out),
    .lcd_write       (lcd_write),
    .lcd_data        (lcd_data)
  );

  // clock / cycle counter
  initial clock = 1'b0;
  always #5 clock = ~clock;
  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic vec_t mk(input string nm, input logic ren, input logic wren,
                              input logic [11:0] addr, input logic [31:0] wdata,
                              input logic [31:0] dq, input logic [31:0] er,
                              input logic ew);
    vec_t v;
    v.nm = nm; v.ren = ren; v.wren = wren; v.addr = addr; v.wdata = wdata;
    v.dq = dq; v.exp_rdata = er; v.exp_dwren = ew;
    return v;
  endfunction

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // one bus cycle: drive, sample combinational outputs, take the edge
  task automatic io(input logic ren, input logic wren, input logic [11:0] addr,
                    input logic [31:0] wdata, input logic [31:0] dq,
                    output logic [31:0] rd, output logic dw);
    cpu_ren = ren; cpu_wren = wren; cpu_address = addr; cpu_wdata = wdata; dmem_q = dq;
    #1;
    rd = cpu_rdata;
    dw = dmem_wren;
    tick();
    cpu_ren = 1'b0; cpu_wren = 1'b0; cpu_address = 12'h000; cpu_wdata = '0; dmem_q = '0;
  endtask

  task automatic rd_chk(input string nm, input logic [11:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic dw;
    io(1'b1, 1'b0, addr, 32'd0, 32'd0, rd, dw);
    check32(nm, rd, exp);
  endtask

  task automatic lcd_sw(input logic [31:0] word, input logic accept);
    logic [31:0] rd;
    logic dw;
    if (accept) exp_q.push_back(word);
    io(1'b0, 1'b1, A_LCD_DATA, word, 32'd0, rd, dw);
  endtask

  task automatic key_press(input logic [7:0] code, input logic accept);
    ps2_out = code;
    ps2_key_pressed = 1'b1;
    if (accept) key_q.push_back(code);
    tick();
    ps2_key_pressed = 1'b0;
    tick();
  endtask

  task automatic key_pop_chk(input string nm);
    logic [31:0] exp;
    exp = (key_q.size() > 0) ? {24'd0, key_q.pop_front()} : 32'd0;
    rd_chk(nm, A_KEY_DATA, exp);
  endtask

  task automatic apply_vec(input vec_t v);
    logic [31:0] rd;
    logic dw;
    if (v.wren && v.addr == A_LCD_DATA) exp_q.push_back(v.wdata);
    io(v.ren, v.wren, v.addr, v.wdata, v.dq, rd, dw);
    check32({v.nm, "_rdata"}, rd, v.exp_rdata);
    check32({v.nm, "_dmem_wren"}, {31'd0, dw}, {31'd0, v.exp_dwren});
  endtask

  // LCD scoreboard: every pulse pops the expected queue and checks pacing
  always @(negedge clock) begin
    if (mon_en) begin
      if (lcd_write === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL lcd_unexpected: pulse with data 0x%08h, none expected", lcd_data);
        end else begin
          check32("lcd_data", lcd_data, exp_q.pop_front());
          if (burst_n > 0) check32("lcd_spacing", cyc - last_pulse, LCD_GAP + 1);
          last_pulse = cyc;
          burst_n++;
        end
      end else begin
        check32("lcd_write_idle", {31'd0, lcd_write}, 32'd0);
        check32("lcd_data_idle", lcd_data, 32'd0);
      end
    end
  end

  // watchdog
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    checks = 0; errors = 0; burst_n = 0; last_pulse = 0; mon_en = 1'b0;
    reset = 1'b0; cpu_address = '0; cpu_wdata = '0; cpu_wren = 1'b0; cpu_ren = 1'b0;
    dmem_q = '0; ps2_key_pressed = 1'b0; ps2_out = '0;

    tbl_a[0] = mk("rst_key_stat", 1, 0, A_KEY_STAT, 0,     0,            0,            0);
    tbl_a[1] = mk("rst_lcd_stat", 1, 0, A_LCD_STAT, 0,     0,            0,            0);
    tbl_a[2] = mk("rst_key_data", 1, 0, A_KEY_DATA, 0,     0,            0,            0);
    tbl_a[3] = mk("dmem_sw",      0, 1, 12'h010,    32'h1234, 0,         0,            1);
    tbl_a[4] = mk("dmem_lw",      1, 0, 12'h010,    0,     32'h1234,     32'h1234,     0);
    tbl_a[5] = mk("lcd_sw",       0, 1, A_LCD_DATA, 32'h5, 0,            0,            0);
    tbl_a[6] = mk("key_data_sw",  0, 1, A_KEY_DATA, 32'h77, 0,           0,            0);
    tbl_a[7] = mk("dmem_sw_fef",  0, 1, 12'hFEF,    32'h9, 32'hCAFEF00D, 32'hCAFEF00D, 1);
    tbl_a[8] = mk("dmem_lw_ff4",  1, 0, 12'hFF4,    0,     32'hDEADBEEF, 32'hDEADBEEF, 0);
    tbl_a[9] = mk("lcd_data_lw",  1, 0, A_LCD_DATA, 0,     32'h11111111, 0,            0);

    tbl_b[0] = mk("key3_stat",    1, 0, A_KEY_STAT, 0, 32'hFFFF, 32'h3,  0);
    tbl_b[1] = mk("key3_data0",   1, 0, A_KEY_DATA, 0, 32'hFFFF, 32'h1C, 0);
    tbl_b[2] = mk("key3_data1",   1, 0, A_KEY_DATA, 0, 32'hFFFF, 32'h32, 0);
    tbl_b[3] = mk("key3_data2",   1, 0, A_KEY_DATA, 0, 32'hFFFF, 32'h21, 0);
    tbl_b[4] = mk("key3_empty",   1, 0, A_KEY_DATA, 0, 32'hFFFF, 32'h0,  0);
    tbl_b[5] = mk("key3_stat0",   1, 0, A_KEY_STAT, 0, 32'hFFFF, 32'h0,  0);

    // reset
    repeat (2) tick();
    check32("rst_lcd_write", {31'd0, lcd_write}, 32'd0);
    check32("rst_lcd_data", lcd_data, 32'd0);
    reset = 1'b1;
    mon_en = 1'b1;

    // dmem passthrough and register map
    burst_n = 0;
    for (int i = 0; i < 10; i++) apply_vec(tbl_a[i]);
    repeat (8) tick();
    check32("dmem_lcd_pulses", burst_n, 1);

    // LCD pacing: two back-to-back stores
    burst_n = 0;
    lcd_sw(32'hA, 1'b1);
    lcd_sw(32'hB, 1'b1);
    repeat (10) tick();
    check32("pace_pulses", burst_n, 2);

    // three keys, then reads
    key_press(8'h1C, 1'b0);
    key_press(8'h32, 1'b0);
    key_press(8'h21, 1'b0);
    for (int i = 0; i < 6; i++) apply_vec(tbl_b[i]);

    // held strobe pushes once
    ps2_out = 8'h5A;
    ps2_key_pressed = 1'b1;
    repeat (10) tick();
    ps2_key_pressed = 1'b0;
    tick();
    rd_chk("key_hold_stat", A_KEY_STAT, 32'h1);
    rd_chk("key_hold_data", A_KEY_DATA, 32'h5A);

    // key overflow: 9 edges into 8 slots
    for (int i = 0; i < 9; i++) key_press(8'h40 + 8'(i), i < 8);
    rd_chk("key_ovf_stat", A_KEY_STAT, 32'h108);
    rd_chk("key_ovf_stat2", A_KEY_STAT, 32'h008);
    for (int i = 0; i < 8; i++) key_pop_chk("key_ovf_data");
    rd_chk("key_ovf_empty", A_KEY_DATA, 32'h0);
    rd_chk("key_ovf_stat0", A_KEY_STAT, 32'h0);

    // full queue: push and pop in the same cycle, no overflow
    for (int i = 0; i < 8; i++) key_press(8'h60 + 8'(i), 1'b1);
    ps2_out = 8'h70;
    ps2_key_pressed = 1'b1;
    key_q.push_back(8'h70);
    key_pop_chk("key_full_simul");
    ps2_key_pressed = 1'b0;
    tick();
    rd_chk("key_full_stat", A_KEY_STAT, 32'h008);
    for (int i = 0; i < 8; i++) key_pop_chk("key_full_data");
    rd_chk("key_full_stat0", A_KEY_STAT, 32'h0);

    // LCD overflow with the drain running: word 0x106 is dropped
    burst_n = 0;
    lcd_sw(32'h100, 1'b1);
    tick();
    for (int i = 1; i <= 6; i++) lcd_sw(32'h100 + 32'(i), i < 6);
    repeat (20) tick();
    check32("lcd_ovf_pulses", burst_n, 6);
    rd_chk("lcd_ovf_stat", A_LCD_STAT, 32'h100);
    rd_chk("lcd_ovf_stat2", A_LCD_STAT, 32'h000);

    // reset during GAP with three words queued
    key_press(8'h55, 1'b0);
    burst_n = 0;
    for (int i = 1; i <= 4; i++) lcd_sw(32'h200 + 32'(i), 1'b1);
    reset = 1'b0;
    check32("mid_gap_write", {31'd0, lcd_write}, 32'd0);
    rd_chk("mid_lcd_stat_pre", A_LCD_STAT, 32'h3);
    reset = 1'b1;
    exp_q.delete();
    check32("mid_lcd_write", {31'd0, lcd_write}, 32'd0);
    rd_chk("mid_lcd_stat", A_LCD_STAT, 32'h0);
    rd_chk("mid_key_stat", A_KEY_STAT, 32'h0);
    repeat (12) tick();
    check32("mid_pulses", burst_n, 1);

    repeat (4) tick();
    check32("lcd_pending", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
